// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_chain slice.
// Holds the default payload width and stage count, and the function that
// sizes the occupancy counter (and any other 0..DEPTH count) for a given depth.
package pipe_pkg;

    localparam int DEF_DATA_W = 32'd8;
    localparam int DEF_DEPTH  = 32'd4;

    // Bits needed to hold a count in the range 0..n (n >= 1).
    function automatic int occ_w(input int n);
        return $clog2(n + 32'd1);
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid flag plus a payload register.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   load           - capture d and mark the stage valid (wins over clear)
//   clear          - drop the entry: valid and data both go to zero
//   d              - payload offered by the predecessor
//   valid, data    - registered stage contents
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;

    // Stage register: load beats clear, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= d;
        end else if (clear) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule : pipe_stage

// File: rtl/pipe_chain.sv
// Elastic pipeline of DEPTH stages with bubble collapse, per-stage kill,
// synchronous flush and a global stall. Stage 0 is the youngest entry,
// stage DEPTH-1 the oldest and drives the output port.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   flush                           - clear every stage on the next edge
//   stall                           - freeze all stages, block both handshakes
//   kill[DEPTH]                     - invalidate stage k this cycle
//   in_valid, in_ready, in_data     - upstream handshake into stage 0
//   out_valid, out_ready, out_data  - downstream handshake from stage DEPTH-1
//   stage_valid, stage_data         - per-stage contents (stage k at slice k)
//   occupancy                       - number of valid stages, registered
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    stall,
    input  logic [DEPTH-1:0]        kill,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [DEPTH-1:0]        stage_valid,
    output logic [DEPTH*DATA_W-1:0] stage_data,
    output logic [occ_w(DEPTH)-1:0] occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [DEPTH-1:0]  valid_s;
    logic [DEPTH-1:0]  live_s;
    logic [DEPTH-1:0]  move_s;
    logic [DEPTH-1:0]  load_s;
    logic [DEPTH-1:0]  clear_s;
    logic [DEPTH-1:0]  nxt_valid_s;
    logic              run_s;
    logic              in_ready_s;
    logic [DATA_W-1:0] data_s [DEPTH];
    logic [OCC_W-1:0]  occ_nxt_s;
    logic [OCC_W-1:0]  occ_r;

    // Move/ready chain, resolved from the oldest stage backwards so a stage
    // may advance into a slot that is itself emptying this cycle.
    always_comb begin
        // rst is folded in so in_ready/out_valid stay low while reset is held.
        run_s  = ~flush & ~stall & ~rst;
        live_s = valid_s & ~kill;
        move_s = '0;
        move_s[DEPTH-1] = run_s & live_s[DEPTH-1] & out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            move_s[k] = run_s & live_s[k] & (~live_s[k+1] | move_s[k+1]);
        end
        in_ready_s = run_s & (~live_s[0] | move_s[0]);
        load_s     = {move_s[DEPTH-2:0], in_valid & in_ready_s};
        // Flush clears unconditionally; stall suppresses kill and move-out.
        clear_s     = {DEPTH{flush}} | ({DEPTH{~stall}} & (kill | move_s));
        nxt_valid_s = load_s | (valid_s & ~clear_s);
    end

    // Population count of the next-state valid bits, so the registered
    // occupancy lines up with stage_valid on every cycle.
    always_comb begin
        occ_nxt_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_nxt_s = occ_nxt_s + OCC_W'(nxt_valid_s[k]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r <= '0;
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [DATA_W-1:0] d_s;
        if (g == 0) begin : g_head
            assign d_s = in_data;
        end else begin : g_body
            assign d_s = data_s[g-1];
        end

        pipe_stage #(.DATA_W(DATA_W)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .load  (load_s[g]),
            .clear (clear_s[g]),
            .d     (d_s),
            .valid (valid_s[g]),
            .data  (data_s[g])
        );

        assign stage_data[g*DATA_W +: DATA_W] = data_s[g];
    end

    assign stage_valid = valid_s;
    assign in_ready    = in_ready_s;
    assign out_valid   = live_s[DEPTH-1] & run_s;
    assign out_data    = data_s[DEPTH-1];
    assign occupancy   = occ_r;

endmodule : pipe_chain

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain (DATA_W=8, DEPTH=4). Accepted inputs
// are pushed to an expected-value queue and delivered outputs are popped
// and compared in order.
module tb_pipe_chain;

    localparam int DW = 8;
    localparam int DP = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            stall = 1'b0;
    logic [DP-1:0]   kill = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [DP-1:0]   stage_valid;
    logic [DP*DW-1:0] stage_data;
    logic [2:0]      occupancy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_out    = 0;
    logic [7:0]  exp_q [$];

    pipe_chain #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .stall       (stall),
        .kill        (kill),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at negedge (or negedge+1); samples handshakes just before the
    // posedge, then returns at the following negedge.
    task automatic tick();
        #3;
        if (in_valid && in_ready) exp_q.push_back(in_data);
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                check_eq("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
        @(negedge clk);
    endtask

    task automatic fill4();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 * (i + 1));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        kill      = '0;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || occupancy != 3'd0); i++) begin
            tick();
        end
        check_eq("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        check_eq("drain_occ", 64'(occupancy), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state, with upstream/downstream both asserting.
        in_valid  = 1'b1;
        in_data   = 8'h99;
        out_ready = 1'b1;
        #1;
        check_eq("rst_stage_valid", 64'(stage_valid), 64'd0);
        check_eq("rst_stage_data", 64'(stage_data), 64'd0);
        check_eq("rst_occ", 64'(occupancy), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Fill then drain in order.
        fill4();
        #1;
        check_eq("fill_stage_valid", 64'(stage_valid), 64'hf);
        check_eq("fill_occ", 64'(occupancy), 64'd4);
        check_eq("fill_in_ready", 64'(in_ready), 64'd0);
        check_eq("fill_stage_data", 64'(stage_data), 64'h11223344);
        check_eq("fill_out_valid", 64'(out_valid), 64'd1);
        n_out = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_eq("fill_n_out", 64'(n_out), 64'd4);
        check_eq("fill_drained_occ", 64'(occupancy), 64'd0);
        out_ready = 1'b0;

        // Single item collapses to the last stage.
        in_valid = 1'b1;
        in_data  = 8'h5a;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #1;
        check_eq("bubble_stage_valid", 64'(stage_valid), 64'h8);
        check_eq("bubble_stage_data", 64'(stage_data), 64'h5a000000);
        check_eq("bubble_in_ready", 64'(in_ready), 64'd1);
        check_eq("bubble_occ", 64'(occupancy), 64'd1);
        drain();

        // Kill stage 2 (0x22) while the oldest entry leaves.
        fill4();
        n_out     = 0;
        kill      = 4'b0100;
        out_ready = 1'b1;
        exp_q.delete(1);
        tick();
        kill      = '0;
        out_ready = 1'b0;
        #1;
        check_eq("kill_stage_valid", 64'(stage_valid), 64'h6);
        check_eq("kill_occ", 64'(occupancy), 64'd2);
        check_eq("kill_stage_data", 64'(stage_data), 64'h00334400);
        drain();
        check_eq("kill_n_out", 64'(n_out), 64'd3);

        // Flush and stall together: flush wins.
        fill4();
        flush     = 1'b1;
        stall     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        #1;
        check_eq("flush_in_ready", 64'(in_ready), 64'd0);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        flush     = 1'b0;
        stall     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        #1;
        check_eq("flush_stage_valid", 64'(stage_valid), 64'd0);
        check_eq("flush_stage_data", 64'(stage_data), 64'd0);
        check_eq("flush_occ", 64'(occupancy), 64'd0);

        // Stall alone for three cycles, with kill and handshakes requested.
        fill4();
        stall     = 1'b1;
        kill      = 4'b1111;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h66;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_out_valid", 64'(out_valid), 64'd0);
            check_eq("stall_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        stall     = 1'b0;
        kill      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_eq("stall_stage_data", 64'(stage_data), 64'h11223344);
        check_eq("stall_stage_valid", 64'(stage_valid), 64'hf);
        check_eq("stall_occ", 64'(occupancy), 64'd4);
        drain();

        // Asynchronous reset between edges with a full chain.
        fill4();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_stage_valid", 64'(stage_valid), 64'd0);
        check_eq("arst_out_data", 64'(out_data), 64'd0);
        check_eq("arst_stage_data", 64'(stage_data), 64'd0);
        check_eq("arst_occ", 64'(occupancy), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd0);
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hc3;
        #1;
        check_eq("arst_first_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        drain();

        // Throughput: 20 cycles streaming in and out.
        n_out     = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(8'h80 + i);
            #1;
            check_eq("tput_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        check_eq("tput_n_out", 64'(n_out), 64'd16);
        in_valid = 1'b0;
        drain();

        check_eq("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_chain

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, legal 1..64.
REQ-002 Parameter DEPTH, default 4: number of stages, legal 2..8.
REQ-003 Port clk  input  1: single clock; all state updates on posedge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port flush  input  1: synchronous clear of all stages.
REQ-006 Port stall  input  1: global freeze; no stage moves while high.
REQ-007 Port kill  input  DEPTH: per-stage invalidate, bit k targets stage k.
REQ-008 Port in_valid  input  1: upstream offers in_data.
REQ-009 Port in_ready  output  1: stage 0 accepts this cycle.
REQ-010 Port in_data  input  DATA_W: payload from upstream.
REQ-011 Port out_valid  output  1: last stage presents out_data.
REQ-012 Port out_ready  input  1: downstream accepts.
REQ-013 Port out_data  output  DATA_W: payload of stage DEPTH-1.
REQ-014 Port stage_valid  output  DEPTH: valid bit of every stage, bit k = stage k.
REQ-015 Port stage_data  output  DEPTH*DATA_W: stage k at bits [k*DATA_W +: DATA_W].
REQ-016 Port occupancy  output  clog2(DEPTH+1): count of valid stages.

Function
REQ-017 Each stage k holds valid_k and data_k; stage 0 is youngest, DEPTH-1 oldest.
REQ-018 Priority per cycle: rst > flush > stall > kill > advance.
REQ-019 live_k = valid_k & ~kill[k]; a killed entry is a bubble this cycle and never forwarded.
REQ-020 Last stage moves when live & out_ready; stage k<DEPTH-1 moves when live & (stage k+1 not live or moving) (bubble collapse).
REQ-021 Stage k loads stage k-1 (or in_data for k=0) when its predecessor moves; otherwise it clears valid if killed or moved out, else holds.
REQ-022 in_ready = ~flush & ~stall & (stage 0 not live or moving); in_ready may depend combinationally on out_ready and kill.
REQ-023 out_valid = live_{DEPTH-1} & ~flush & ~stall; out_data = data_{DEPTH-1}.
REQ-024 Transfer occurs only when valid and ready are both high in the same cycle, in and out independently.
REQ-025 Latency: an item entering an empty chain appears at out_valid DEPTH cycles after its accept edge.
REQ-026 Full chain with out_ready=1 sustains one accept and one delivery per cycle.
REQ-027 Flush: next edge zeroes every valid bit and every data field; in and out handshakes blocked that cycle.
REQ-028 Stall: all valid and data hold; kill ignored; in_ready=0, out_valid=0.
REQ-029 A cleared stage (kill or move-out without refill) zeroes its data field.
REQ-030 occupancy equals popcount(stage_valid) registered, range 0..DEPTH; never wraps.
REQ-031 Item order preserved; no item duplicated or dropped except by kill or flush.

Reset
REQ-032 rst high asynchronously forces all valid bits 0, all data 0, occupancy 0.
REQ-033 While rst high: in_ready=0, out_valid=0, stage_valid=0, stage_data=0, out_data=0.
REQ-034 rst asserted mid-transfer discards all in-flight items; first accept allowed on first edge after release.

Structure
REQ-035 Shared package pipe_pkg holds default DATA_W/DEPTH constants and the stage-index/occupancy width function.
REQ-036 One sub-module pipe_stage (valid+data register with load/clear/hold) instantiated DEPTH times by generate; move/ready chain lives in pipe_chain.

Verification (DATA_W=8, DEPTH=4)
REQ-037 Fill: push 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=0 -> stage_valid=4'b1111, occupancy=4, in_ready=0; then out_ready=1 -> out 0x11..0x44 in order, one per cycle.
REQ-038 Bubble collapse: single push 0x5A into empty chain, out_ready=0 -> 0x5A reaches stage 3 after 4 edges, stages 0-2 empty, in_ready=1.
REQ-039 Kill: chain holds 0x11..0x44 (0x44 youngest in stage 0), kill=4'b0100 one cycle, out_ready=1 -> outputs 0x11,0x33,0x44; occupancy drops correctly.
REQ-040 Flush vs stall: full chain, flush=1 and stall=1 same cycle -> next edge all stages 0x00, occupancy=0; stall alone for 3 cycles -> contents unchanged, out_valid=0.
REQ-041 Async reset: assert rst between edges with full chain -> stage_valid=0, out_data=0x00 immediately, before next clk edge.
REQ-042 Throughput: continuous in_valid=1, out_ready=1 for 20 cycles with incrementing data -> 16 outputs after 4-cycle latency, none missing, in_ready never low.
